// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: holds MULT/DIV busy for a fixed
// cycle count, owns HI/LO, and generates the D-stage stall for HI/LO users.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    op_reg;
  logic [31:0]   rs_reg;
  logic [31:0]   rt_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;

  // Result datapath works on the latched operands; it is only consumed on
  // the final busy edge, so a single combinational stage is sufficient.
  logic        is_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_p;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  always_comb begin
    is_signed = ~op_reg[0];
    mul_a     = {{32{is_signed & rs_reg[31]}}, rs_reg};
    mul_b     = {{32{is_signed & rt_reg[31]}}, rt_reg};
    mul_p     = mul_a * mul_b;
  end

  // Sign-magnitude division: |0x80000000| still fits in 32 unsigned bits,
  // so the overflow case needs no special handling.
  always_comb begin
    a_neg       = is_signed & rs_reg[31];
    b_neg       = is_signed & rt_reg[31];
    a_mag       = a_neg ? (~rs_reg + 32'd1) : rs_reg;
    b_mag       = b_neg ? (~rt_reg + 32'd1) : rt_reg;
    div_by_zero = (rt_reg == 32'd0);
    div_den     = div_by_zero ? 32'd1 : b_mag;
    q_mag       = a_mag / div_den;
    r_mag       = a_mag % div_den;
    quot        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem         = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_reg    <= op[1:0];
                rs_reg    <= rs;
                rt_reg    <= rt;
                cnt_reg   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_reg <= RUN;
              end
              OP_MTHI: hi_reg <= rs;
              OP_MTLO: lo_reg <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is deliberately ignored here; operands stay as latched.
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= IDLE;
            if (!op_reg[1]) begin
              hi_reg <= mul_p[63:32];
              lo_reg <= mul_p[31:0];
            end else if (!div_by_zero) begin
              hi_reg <= rem;
              lo_reg <= quot;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg == RUN);
  assign stall = md_use & (busy | (start & ~op[2]));
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised + directed bench for mdu_ctrl against a cycle-count/arithmetic
// reference model of the HI/LO and busy/stall behaviour.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycles of busy left, architectural HI/LO and
  // the result that lands when the countdown expires.
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  bit          m_wr   = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .md_use (md_use),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      m_wr = 1'b1;
      case (o)
        3'd0: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; m_left = MC; end
        3'd1: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; m_left = MC; end
        3'd2: begin
          m_left = DC;
          if (b == 0) m_wr = 1'b0;
          else begin sp = sa / sb; p_lo = sp[31:0]; sp = sa % sb; p_hi = sp[31:0]; end
        end
        3'd3: begin
          m_left = DC;
          if (b == 0) m_wr = 1'b0;
          else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive at negedge, compare just after, advance model, wait edge.
  task automatic cycle(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic mu);
    @(negedge clk);
    start = s; op = o; rs = a; rt = b; md_use = mu;
    #1;
    check("busy", busy, m_left > 0);
    check("stall", stall, mu & ((m_left > 0) | (s & (o < 3'd4))));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    model_edge(s, o, a, b);
    @(posedge clk);
  endtask

  task automatic wait_idle(input logic mu);
    for (int k = 0; k < 64 && m_left > 0; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, mu);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mu);
    cycle(1'b1, o, a, b, mu);
    wait_idle(mu);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 3'd0; rs = '0; rt = '0; md_use = 1'b1;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall_start", stall, 1'b1);
    start = 1'b0;
    #1;
    check("rst_stall_idle", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);
    do_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);
    do_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b1);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'd0);

    do_op(3'd4, 32'h11, 32'd0, 1'b1);
    do_op(3'd5, 32'h22, 32'd0, 1'b1);
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    do_op(3'd2, 32'd1234, 32'd0, 1'b1);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Second start mid-DIV must be ignored and not stretch the busy window.
    cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
    for (int k = 1; k <= DC; k++)
      cycle(k == 3, 3'd0, 32'hFFFFFFFF, 32'h3, 1'b1);
    #1;
    check("ign_busy", busy, 1'b0);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);

    // Asynchronous reset mid-MULT, away from the clock edge.
    cycle(1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
    for (int k = 1; k <= 3; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    #1;
    reset = 1'b0;
    m_left = 0; m_hi = '0; m_lo = '0; m_wr = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    for (int it = 0; it < 150; it++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 15))
        0, 1: b = 32'd0;
        2:    begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3:    b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      cycle(1'b1, o, a, b, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 64 && m_left > 0; k++)
        cycle(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
              1'($urandom_range(0, 1)));
      for (int k = $urandom_range(0, 2); k > 0; k--)
        cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with built-in sequencer for the pipelined MIPS core, placed alongside the ALU in the E stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, holds them busy for a fixed, parameterised number of cycles, and owns the architectural HI/LO registers. It also generates the D-stage stall that keeps any HI/LO-touching instruction out of E while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range ≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range ≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MDU op this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no effect
- rs  in  32  forwarded GPR[rs] operand (dividend / multiplicand / MT source)
- rt  in  32  forwarded GPR[rt] operand (divisor / multiplier)
- md_use  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- busy  out  1  operation in flight
- stall  out  1  freeze PC and F/D, bubble into E
- hi  out  32  HI register, read by MFHI
- lo  out  32  LO register, read by MFLO

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter cnt).
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU, sampled at edge: latch op/rs/rt, load cnt = MULT_CYCLES or DIV_CYCLES, enter RUN.
- IDLE, start=1, op=MTHI: hi<=rs at that edge. op=MTLO: lo<=rs at that edge. busy stays 0.
- IDLE, start=1, op=11x: no state change.
- RUN: cnt decrements each edge. At the edge where cnt goes 1->0, HI/LO are written and the block returns to IDLE.
- start while busy=1 is ignored. The stall logic guarantees this does not occur, but the block must not corrupt state if it does.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- rt=0 on DIV/DIVU: full busy period still runs; hi/lo are left unchanged.
- Result computation is free (single-cycle combinational or iterative). Only the busy window and write timing are fixed.
- stall = md_use & (busy | (start & op∈{MULT,MULTU,DIV,DIVU})), combinational.
- hi/lo are direct register outputs; no bypass of an in-flight result.

## Timing
- Reset (asynchronous, immediate): busy=0, cnt=0, hi=0, lo=0, stall=md_use&start-term only.
- Reset asserted mid-RUN aborts the operation. hi/lo read 0, and the pending result is never written.
- Start sampled at edge t0:
  - busy=1 from just after t0 through edge t0+N, where N is the op's cycle parameter.
  - New hi/lo are visible just after edge t0+N, in the same cycle busy drops.
  - The earliest accepted next start is the edge t0+N+1.
- MTHI/MTLO: 1-cycle latency. The value is visible after the sampling edge.
- stall has zero latency: it rises in the same cycle as start and falls in the first cycle with busy=0.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- hi=0x11, lo=0x22 preloaded via MTHI/MTLO, then DIV rt=0 -> busy for 10 cycles; hi=0x11 and lo=0x22 afterwards.
- md_use=1 held with DIV start at t0 -> stall=1 in the start cycle and for all 10 busy cycles; stall=0 in the cycle busy falls. md_use=0 -> stall=0 throughout.
- Second start (MULT) pulsed at t0+3 during a DIV -> ignored; the DIV result lands at t0+10 and busy falls at t0+10 with no extension.
- Reset pulsed at t0+4 during a MULT (outside clock edge) -> busy, hi and lo read 0 immediately, and they remain 0 after reset deasserts with no start issued.
